sda_kernel_control: RTL and testbench

Host-facing control register block that sits directly upstream of the kernel action top (`teak_action_top_gmem`). It terminates the 32-bit AXI4-Lite slave control bus and exposes start/done/idle status, an interrupt, and the 64-bit parameter buffer base address. It drives the action's `go` request/acknowledge pair and `done` request/acknowledge pair, and drives `param_buf_base`.

---
 rtl/sda_kernel_control_pkg.sv | 35 +++
 rtl/sda_axil_reg_port.sv | 77 +++++++
 rtl/sda_kernel_control.sv | 169 ++++++++++++++++
 tb/tb_sda_kernel_control.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sda_kernel_control_pkg.sv
// Shared constants for the kernel control block: register map, CTRL bits, FSM encoding.
package sda_kernel_control_pkg;

  localparam logic [31:0] OfsCtrl    = 32'h00;
  localparam logic [31:0] OfsGie     = 32'h04;
  localparam logic [31:0] OfsIer     = 32'h08;
  localparam logic [31:0] OfsIsr     = 32'h0C;
  localparam logic [31:0] OfsParamLo = 32'h10;
  localparam logic [31:0] OfsParamHi = 32'h14;

  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlDoneBit  = 1;
  localparam int unsigned CtrlIdleBit  = 2;

  localparam logic [1:0] RespOkay = 2'b00;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGo     = 2'd1,
    StRun    = 2'd2,
    StFinish = 2'd3
  } state_e;

  // Merge the byte lanes selected by strb from wdata into cur.
  function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] wdata,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sda_axil_reg_port.sv
// AXI4-Lite slave handshake; turns bus transactions into one-cycle write and read strobes.
module sda_axil_reg_port
  import sda_kernel_control_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [31:0]          s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic [3:0]           wr_strb,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [31:0]          rd_data
);

  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q;

  // A new transaction is taken only once the previous one has fully drained.
  assign wr_en   = s_axi_awvalid & s_axi_wvalid & ~awready_q & ~bvalid_q;
  assign wr_addr = s_axi_awaddr[ADDR_BITS-1:0];
  assign wr_data = s_axi_wdata;
  assign wr_strb = s_axi_wstrb;
  assign rd_en   = s_axi_arvalid & ~arready_q & ~rvalid_q;
  assign rd_addr = s_axi_araddr[ADDR_BITS-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= wr_en;
      if (awready_q) bvalid_q <= 1'b1;
      else if (s_axi_bready) bvalid_q <= 1'b0;

      arready_q <= rd_en;
      if (rd_en) rdata_q <= rd_data;
      if (arready_q) rvalid_q <= 1'b1;
      else if (s_axi_rready) rvalid_q <= 1'b0;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = RespOkay;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = RespOkay;

  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[31:ADDR_BITS], s_axi_araddr[31:ADDR_BITS]};

endmodule

// File: rtl/sda_kernel_control.sv
// Kernel control registers and go/done action FSM behind an AXI4-Lite slave.
// Interrupt registers (GIE/IER/ISR) exist only when SDA_KERNEL_CONTROL_IRQ_EN is defined.
module sda_kernel_control
  import sda_kernel_control_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  output logic [63:0] param_buf_base,
  output logic        interrupt
);

  logic                 wr_en, rd_en;
  logic [ADDR_BITS-1:0] wr_addr, rd_addr;
  logic [31:0]          wr_data, rd_data;
  logic [3:0]           wr_strb;

  sda_axil_reg_port #(
    .ADDR_BITS(ADDR_BITS)
  ) u_port (
    .clk          (clk),
    .reset        (reset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  // Word-aligned byte offsets; address bits [1:0] never select anything.
  logic [31:0] wr_ofs, rd_ofs;
  assign wr_ofs = 32'({wr_addr[ADDR_BITS-1:2], 2'b00});
  assign rd_ofs = 32'({rd_addr[ADDR_BITS-1:2], 2'b00});

  logic unused_lsb;
  assign unused_lsb = ^{wr_addr[1:0], rd_addr[1:0]};

  state_e      state_q, state_d;
  logic        ap_start_q, ap_done_q;
  logic [63:0] param_q;
  logic        start_wr, done_set;

  assign start_wr = wr_en && (wr_ofs == OfsCtrl) && wr_strb[0] && wr_data[CtrlStartBit] &&
                    (state_q == StIdle);
  assign done_set = (state_q == StRun) && done_0r;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_wr) state_d = StGo;
      StGo:     if (go_0a)    state_d = StRun;
      StRun:    if (done_0r)  state_d = StFinish;
      StFinish: if (!done_0r) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    go_0r   = (state_q == StGo);
    done_0a = (state_q == StRun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      param_q    <= '0;
    end else begin
      if (start_wr) ap_start_q <= 1'b1;
      else if ((state_q == StGo) && go_0a) ap_start_q <= 1'b0;
      // A hardware set beats clear-on-read landing on the same edge.
      if (done_set) ap_done_q <= 1'b1;
      else if (rd_en && (rd_ofs == OfsCtrl)) ap_done_q <= 1'b0;
      if (wr_en && (wr_ofs == OfsParamLo)) param_q[31:0] <= apply_strb(param_q[31:0], wr_data, wr_strb);
      if (wr_en && (wr_ofs == OfsParamHi)) param_q[63:32] <= apply_strb(param_q[63:32], wr_data, wr_strb);
    end
  end

  assign param_buf_base = param_q;

`ifdef SDA_KERNEL_CONTROL_IRQ_EN
  logic gie_q, ier_q, isr_q, irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gie_q <= 1'b0;
      ier_q <= 1'b0;
      isr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && (wr_ofs == OfsGie) && wr_strb[0]) gie_q <= wr_data[0];
      if (wr_en && (wr_ofs == OfsIer) && wr_strb[0]) ier_q <= wr_data[0];
      if (done_set) isr_q <= 1'b1;
      else if (wr_en && (wr_ofs == OfsIsr) && wr_strb[0] && wr_data[0]) isr_q <= ~isr_q;
      irq_q <= gie_q & ier_q & isr_q;
    end
  end

  assign interrupt = irq_q;
`else
  assign interrupt = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_ofs)
      OfsCtrl: begin
        rd_data[CtrlStartBit] = ap_start_q;
        rd_data[CtrlDoneBit]  = ap_done_q;
        rd_data[CtrlIdleBit]  = (state_q == StIdle);
      end
`ifdef SDA_KERNEL_CONTROL_IRQ_EN
      OfsGie:     rd_data[0] = gie_q;
      OfsIer:     rd_data[0] = ier_q;
      OfsIsr:     rd_data[0] = isr_q;
`endif
      OfsParamLo: rd_data = param_q[31:0];
      OfsParamHi: rd_data = param_q[63:32];
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_sda_kernel_control.sv
// Directed self-checking bench for sda_kernel_control; the bench plays the action stub.
module tb_sda_kernel_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b1;
  logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b1;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;
  logic        go_0r, done_0a, interrupt;
  logic        go_0a = 1'b0, done_0r = 1'b0;
  logic [63:0] param_buf_base;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd;

`ifdef SDA_KERNEL_CONTROL_IRQ_EN
  localparam logic IrqOn = 1'b1;
`else
  localparam logic IrqOn = 1'b0;
`endif

  always #5 clk = ~clk;

  sda_kernel_control #(
    .ADDR_BITS(6)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .go_0r         (go_0r),
    .go_0a         (go_0a),
    .done_0r       (done_0r),
    .done_0a       (done_0a),
    .param_buf_base(param_buf_base),
    .interrupt     (interrupt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_req(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_awready && n < 20);
    check("aw_latency", 64'(n), 64'd1);
    check("wready_with_awready", {s_axi_awready, s_axi_wready}, 2'b11);
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("awready_one_cycle", s_axi_awready, 1'b0);
    check("bvalid_rise", {s_axi_bvalid, s_axi_bresp}, 3'b100);
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    while (s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
    check("bvalid_fall", s_axi_bvalid, 1'b0);
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    write_req(addr, data, strb);
    wait_b();
  endtask

  task automatic read_req(input logic [31:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_arready && n < 20);
    check("ar_latency", 64'(n), 64'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("rvalid_rise", {s_axi_arready, s_axi_rvalid, s_axi_rresp}, 4'b0100);
    data = s_axi_rdata;
  endtask

  task automatic wait_r();
    int n;
    n = 0;
    while (s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    check("rvalid_fall", s_axi_rvalid, 1'b0);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    read_req(addr, d);
    wait_r();
    check(tag, d, exp);
  endtask

  task automatic check_outs_zero(input string tag);
    check(tag, {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                go_0r, done_0a, interrupt, s_axi_rdata, param_buf_base},
          '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_outs_zero("outs_in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_outs_zero("outs_after_reset");
    read_check("ctrl_idle", 32'h00, 32'h4);

    // Parameter buffer base, full and byte-enabled writes, address aliasing.
    write(32'h10, 32'h1234_5678, 4'hF);
    write(32'h14, 32'hDEAD_BEEF, 4'hF);
    check("param_full", param_buf_base, 64'hDEADBEEF_12345678);
    write(32'h10, 32'h0000_00FF, 4'h1);
    check("param_strb_lo", param_buf_base, 64'hDEADBEEF_123456FF);
    write(32'h56, 32'hCAFE_F00D, 4'h3);
    check("param_alias_hi", param_buf_base, 64'hDEADF00D_123456FF);
    read_check("param_hi_rd", 32'h14, 32'hDEAD_F00D);
    write(32'h18, 32'hFFFF_FFFF, 4'hF);
    read_check("unmapped_rd", 32'h18, 32'h0);

    // Start with wstrb[0]=0 must not start.
    write(32'h00, 32'h1, 4'hE);
    check("start_nostrb", go_0r, 1'b0);
    read_check("ctrl_nostrb", 32'h00, 32'h4);

    write(32'h04, 32'h1, 4'hF);
    write(32'h08, 32'h1, 4'hF);
    read_check("gie_rd", 32'h04, {31'b0, IrqOn});
    read_check("ier_rd", 32'h08, {31'b0, IrqOn});

    // Full run through GO, RUN, FINISH.
    write(32'h00, 32'h1, 4'hF);
    check("go_after_start", {go_0r, done_0a}, 2'b10);
    read_check("ctrl_go", 32'h00, 32'h1);
    check("go_held", go_0r, 1'b1);
    go_0a = 1'b1;
    @(negedge clk);
    go_0a = 1'b0;
    check("run_outs", {go_0r, done_0a}, 2'b01);
    write(32'h00, 32'h1, 4'hF);
    check("start_in_run_ignored", {go_0r, done_0a}, 2'b01);
    read_check("ctrl_run", 32'h00, 32'h0);
    done_0r = 1'b1;
    @(negedge clk);
    check("finish_outs", {go_0r, done_0a, interrupt}, 3'b000);
    done_0r = 1'b0;
    @(negedge clk);
    check("irq_rise", interrupt, IrqOn);
    read_check("ctrl_done_first", 32'h00, 32'h6);
    read_check("ctrl_done_cleared", 32'h00, 32'h4);
    read_check("isr_rd", 32'h0C, {31'b0, IrqOn});
    write(32'h0C, 32'h1, 4'hF);
    check("irq_after_isr_toggle", interrupt, 1'b0);
    read_check("isr_cleared", 32'h0C, 32'h0);

    // Done set on the same edge as a CTRL read: the read sees 0, done stays set.
    write(32'h00, 32'h1, 4'hF);
    go_0a = 1'b1;
    @(negedge clk);
    go_0a = 1'b0;
    s_axi_araddr = 32'h00;
    s_axi_arvalid = 1'b1;
    done_0r = 1'b1;
    @(negedge clk);
    check("collide_arready", {s_axi_arready, done_0a}, 2'b10);
    done_0r = 1'b0;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    check("collide_rdata", {s_axi_rvalid, s_axi_rdata}, {1'b1, 32'h0});
    wait_r();
    read_check("collide_done_kept", 32'h00, 32'h6);
    read_check("collide_done_cleared", 32'h00, 32'h4);

    // Backpressure on both response channels.
    s_axi_bready = 1'b0;
    write_req(32'h10, 32'hA5A5_A5A5, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bvalid_stall", s_axi_bvalid, 1'b1);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    check("bvalid_release", s_axi_bvalid, 1'b0);
    s_axi_rready = 1'b0;
    read_req(32'h10, rd);
    check("rdata_stall_first", rd, 32'hA5A5_A5A5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rvalid_stall", {s_axi_rvalid, s_axi_rdata}, {1'b1, 32'hA5A5_A5A5});
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    check("rvalid_release", s_axi_rvalid, 1'b0);

    // Reset in GO.
    write(32'h00, 32'h1, 4'hF);
    check("go_before_reset", go_0r, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("go_reset_drop", {go_0r, done_0a}, 2'b00);
    reset = 1'b0;
    check("param_reset", param_buf_base, 64'h0);
    read_check("ctrl_after_go_reset", 32'h00, 32'h4);

    // Reset in RUN.
    write(32'h00, 32'h1, 4'hF);
    go_0a = 1'b1;
    @(negedge clk);
    go_0a = 1'b0;
    check("run_before_reset", done_0a, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("run_reset_drop", {go_0r, done_0a}, 2'b00);
    reset = 1'b0;
    read_check("ctrl_after_run_reset", 32'h00, 32'h4);
    check("irq_after_reset", interrupt, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
